instr_reader: RTL
=================

INSTR_READER -- requirements
Module: instr_reader

Interface
REQ-001 SHALL have no parameters; widths are fixed: address 5 bits (32 entries), count 6 bits, opcode 4 bits, operands 32-bit signed, result 64-bit signed.
REQ-002 SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  request a read/execute run.
- first_ptr  in  5  first register entry to read.
- count  in  6  number of entries to process, 0..32.
- instruction_word  in  68  {opc[67:64], op_a[63:32], op_b[31:0]} from instruction register, combinational function of read_pointer.
- read_pointer  out  5  registered read address to instruction register.
- result_valid  out  1  result/result_opc/result_ptr/div_err valid.
- result_ready  in  1  consumer accepts result.
- result  out  64  signed result.
- result_opc  out  4  opcode of executed instruction.
- result_ptr  out  5  entry address the result came from.
- div_err  out  1  DIV/MOD with op_b==0.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.

Function
REQ-003 SHALL implement FSM states IDLE, FETCH, EXEC, HOLD; busy=1 in every state except IDLE.
REQ-004 IDLE: start=1, count!=0 -> ptr<=first_ptr, remaining<=count, next FETCH; start=1, count==0 -> done=1 next cycle, stay IDLE; otherwise stay IDLE.
REQ-005 start SHALL be ignored while busy=1.
REQ-006 FETCH: read_pointer drives ptr throughout; instruction_word captured into internal register on the closing edge; next EXEC.
REQ-007 EXEC: result computed from captured instruction, registered into outputs with result_valid<=1, result_ptr<=ptr; next HOLD.
REQ-008 Opcode decode, operands sign-extended to 64 bits: 0 ZERO->0; 1 PASSA->op_a; 2 PASSB->op_b; 3 ADD->a+b; 4 SUB->a-b; 5 MULT->a*b (full 64-bit signed product); 6 DIV->a/b (truncate toward zero); 7 MOD->a%b (sign follows a); 8..15 ->0.
REQ-009 DIV/MOD with op_b==0 SHALL give result=0, div_err=1; div_err=0 in all other cases.
REQ-010 HOLD: result_valid=1 and all result outputs stable until result_ready=1 on a rising edge.
REQ-011 HOLD with result_ready=1: result_valid<=0, remaining<=remaining-1; if remaining==1 -> IDLE with done=1 that cycle; else ptr<=ptr+1, next FETCH.
REQ-012 ptr SHALL wrap 31->0 (modulo 32); count=32 reads every entry exactly once.
REQ-013 Minimum throughput: one result per 3 cycles with result_ready held high; first result_valid asserted 3 cycles after start sampled.
REQ-014 result_ready while result_valid=0 SHALL have no effect.
REQ-015 done and result_valid SHALL never be 1 in the same cycle.

Reset
REQ-016 reset_n=0 SHALL immediately force IDLE and read_pointer=0, result_valid=0, result=0, result_opc=0, result_ptr=0, div_err=0, busy=0, done=0, internal ptr/remaining/instruction register=0.
REQ-017 Reset asserted mid-run SHALL abort the run with no done pulse; first valid start after reset_n deasserts begins a fresh run.

Verification
REQ-018 Entries 0..2 = {ADD 5,3},{SUB 5,8},{MULT -4,6}; start, first_ptr=0, count=3, ready=1 -> results 8, -3, -24, result_ptr 0,1,2, done pulse after third accept.
REQ-019 Entry 7 = {DIV 7,0}, entry 8 = {MOD -7,2}; first_ptr=7, count=2 -> result 0 with div_err=1, then -1 with div_err=0.
REQ-020 first_ptr=30, count=4 -> read_pointer sequence 30,31,0,1; exactly 4 results; done once.
REQ-021 ready=0 for 5 cycles during HOLD -> result_valid and outputs unchanged for those cycles; advance only after ready=1; second start pulsed mid-run ignored.
REQ-022 count=0 with start -> no result_valid, done=1 the next cycle, busy stays 0.
REQ-023 reset_n pulled low in EXEC of second instruction -> all outputs 0 asynchronously, no done; new start afterwards restarts from its own first_ptr.

Source files
------------

// File: rtl/instr_reader.sv
// Instruction reader: walks a window of the 32-entry instruction register,
// executes each entry and hands results out over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for start; count==0 requests just pulse done
//   FETCH | read_pointer presents ptr, instruction captured on exit
//   EXEC  | captured instruction evaluated, result registered
//   HOLD  | result_valid held until the consumer takes it
module instr_reader (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         first_ptr,
  input  logic [5:0]         count,
  input  logic [67:0]        instruction_word,
  output logic [4:0]         read_pointer,
  output logic               result_valid,
  input  logic               result_ready,
  output logic signed [63:0] result,
  output logic [3:0]         result_opc,
  output logic [4:0]         result_ptr,
  output logic               div_err,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HOLD} state_t;

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;

  state_t             state_q, state_d;
  logic [4:0]         ptr_q, ptr_d;
  logic [5:0]         remaining_q, remaining_d;
  logic [67:0]        instr_q, instr_d;
  logic               result_valid_q, result_valid_d;
  logic signed [63:0] result_q, result_d;
  logic [3:0]         result_opc_q, result_opc_d;
  logic [4:0]         result_ptr_q, result_ptr_d;
  logic               div_err_q, div_err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic signed [63:0] op_a_ext;
  logic signed [63:0] op_b_ext;
  logic signed [63:0] alu_res;
  logic               alu_err;

  // Operands widened to 64 bits so the product and quotient never overflow.
  always_comb begin
    op_a_ext = {{32{instr_q[63]}}, instr_q[63:32]};
    op_b_ext = {{32{instr_q[31]}}, instr_q[31:0]};
    alu_res  = '0;
    alu_err  = 1'b0;
    case (instr_q[67:64])
      OPC_ZERO:  alu_res = '0;
      OPC_PASSA: alu_res = op_a_ext;
      OPC_PASSB: alu_res = op_b_ext;
      OPC_ADD:   alu_res = op_a_ext + op_b_ext;
      OPC_SUB:   alu_res = op_a_ext - op_b_ext;
      OPC_MULT:  alu_res = op_a_ext * op_b_ext;
      OPC_DIV: begin
        if (op_b_ext == 64'sd0) alu_err = 1'b1;
        else                    alu_res = op_a_ext / op_b_ext;
      end
      OPC_MOD: begin
        if (op_b_ext == 64'sd0) alu_err = 1'b1;
        else                    alu_res = op_a_ext % op_b_ext;
      end
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    remaining_d    = remaining_q;
    instr_d        = instr_q;
    result_valid_d = result_valid_q;
    result_d       = result_q;
    result_opc_d   = result_opc_q;
    result_ptr_d   = result_ptr_q;
    div_err_d      = div_err_q;
    busy_d         = busy_q;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != 6'd0) begin
            ptr_d       = first_ptr;
            remaining_d = count;
            busy_d      = 1'b1;
            state_d     = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        instr_d = instruction_word;
        state_d = EXEC;
      end
      EXEC: begin
        result_d       = alu_res;
        result_opc_d   = instr_q[67:64];
        result_ptr_d   = ptr_q;
        div_err_d      = alu_err;
        result_valid_d = 1'b1;
        state_d        = HOLD;
      end
      HOLD: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          remaining_d    = remaining_q - 6'd1;
          if (remaining_q == 6'd1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ptr_d   = ptr_q + 5'd1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      remaining_q    <= '0;
      instr_q        <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_opc_q   <= '0;
      result_ptr_q   <= '0;
      div_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      remaining_q    <= remaining_d;
      instr_q        <= instr_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_opc_q   <= result_opc_d;
      result_ptr_q   <= result_ptr_d;
      div_err_q      <= div_err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign read_pointer = ptr_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign result_opc   = result_opc_q;
  assign result_ptr   = result_ptr_q;
  assign div_err      = div_err_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
